// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, widths and difficulty-to-period lookup for the game sequencer
package game_pkg;
  localparam int TIME_W  = 6;
  localparam int SCORE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Difficulties 2 and 3 share the fastest mole period.
  function automatic logic [31:0] mole_period(input logic [1:0] diff, input logic [31:0] p0,
                                              input logic [31:0] p1, input logic [31:0] p2);
    case (diff)
      2'd0:    return p0;
      2'd1:    return p1;
      default: return p2;
    endcase
  endfunction
endpackage

// File: rtl/strobe_div.sv
// rtl/strobe_div.sv - free-running divider emitting a one-cycle tick every period cycles while enabled
module strobe_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  assign tick = en && (count == period - ONE);

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= tick ? '0 : count + ONE;
  end
endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - whack-a-mole round sequencer; HIGH_SCORE_EN enables high-score tracking
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [31:0] TICK_DIV   = 32'd100_000_000,
  parameter int unsigned READY_SECS = 3,
  parameter logic [31:0] MOLE_P0    = 32'd200_000_000,
  parameter logic [31:0] MOLE_P1    = 32'd120_000_000,
  parameter logic [31:0] MOLE_P2    = 32'd80_000_000
) (
  input  logic               CLK100MHZ,
  input  logic               RST_BTN,
  input  logic               start,
  input  logic [TIME_W-1:0]  gametime,
  input  logic [1:0]         difficulty,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               setup_en,
  output logic               score_clr,
  output logic               game_start,
  output logic               playing,
  output logic               mole_en,
  output logic               game_end,
  output logic [TIME_W-1:0]  timeleft,
  output logic [1:0]         ready_left,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);
  localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);

  state_t              st, st_n;
  logic [TIME_W-1:0]   gt_lat, gt_n, tl_n;
  logic [1:0]          diff_lat, diff_n, rl_n;
  logic                clr_n, gs_n, end_n, mole_n;
  logic                sec_tick, mole_tick, div_clr;

  assign state    = st;
  assign setup_en = (st == S_IDLE);
  assign playing  = (st == S_PLAY);
  // Every state change restarts both dividers so each phase counts from its own entry.
  assign div_clr  = (st_n != st);

  strobe_div #(.W(32)) u_sec_div (
    .clk(CLK100MHZ), .rst(RST_BTN), .clr(div_clr),
    .en(st == S_READY || st == S_PLAY), .period(TICK_DIV), .tick(sec_tick)
  );

  strobe_div #(.W(32)) u_mole_div (
    .clk(CLK100MHZ), .rst(RST_BTN), .clr(div_clr),
    .en(st == S_PLAY), .period(mole_period(diff_lat, MOLE_P0, MOLE_P1, MOLE_P2)),
    .tick(mole_tick)
  );

  always_comb begin
    st_n   = st;
    rl_n   = ready_left;
    tl_n   = timeleft;
    gt_n   = gt_lat;
    diff_n = diff_lat;
    clr_n  = 1'b0;
    gs_n   = 1'b0;
    end_n  = 1'b0;
    mole_n = 1'b0;
    case (st)
      S_IDLE: begin
        if (start && gametime != '0) begin
          st_n   = S_READY;
          gt_n   = gametime;
          diff_n = difficulty;
          rl_n   = 2'(READY_SECS);
          clr_n  = 1'b1;
        end
      end
      S_READY: begin
        if (sec_tick) begin
          rl_n = ready_left - 2'd1;
          if (ready_left == 2'd1) begin
            st_n = S_PLAY;
            tl_n = gt_lat;
            gs_n = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (sec_tick) begin
          tl_n = timeleft - T_ONE;
          if (timeleft == T_ONE) begin
            st_n  = S_OVER;
            end_n = 1'b1;
          end
        end
        mole_n = mole_tick && !end_n;
      end
      default: begin
        tl_n = '0;
        if (start) st_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      st         <= S_IDLE;
      ready_left <= '0;
      timeleft   <= '0;
      gt_lat     <= '0;
      diff_lat   <= '0;
      score_clr  <= 1'b0;
      game_start <= 1'b0;
      game_end   <= 1'b0;
      mole_en    <= 1'b0;
    end else begin
      st         <= st_n;
      ready_left <= rl_n;
      timeleft   <= tl_n;
      gt_lat     <= gt_n;
      diff_lat   <= diff_n;
      score_clr  <= clr_n;
      game_start <= gs_n;
      game_end   <= end_n;
      mole_en    <= mole_n;
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else if (end_n) begin
      if (score > high_score) begin
        high_score <= score;
        new_record <= 1'b1;
      end
    end else if (st == S_OVER && st_n != S_OVER) begin
      new_record <= 1'b0;
    end
  end
`else
  logic unused_score;
  assign unused_score = ^score;
  assign high_score   = '0;
  assign new_record   = 1'b0;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer with directed rounds and resets
module tb_game_sequencer;
  logic       CLK100MHZ = 1'b0;
  logic       RST_BTN   = 1'b1;
  logic       start     = 1'b0;
  logic [5:0] gametime  = '0;
  logic [1:0] difficulty = '0;
  logic [7:0] score     = '0;
  logic [1:0] state;
  logic       setup_en, score_clr, game_start, playing, mole_en, game_end, new_record;
  logic [5:0] timeleft;
  logic [1:0] ready_left;
  logic [7:0] high_score;

`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  game_sequencer #(
    .TICK_DIV(32'd10), .READY_SECS(3),
    .MOLE_P0(32'd20), .MOLE_P1(32'd12), .MOLE_P2(32'd8)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .RST_BTN(RST_BTN), .start(start), .gametime(gametime),
    .difficulty(difficulty), .score(score), .state(state), .setup_en(setup_en),
    .score_clr(score_clr), .game_start(game_start), .playing(playing), .mole_en(mole_en),
    .game_end(game_end), .timeleft(timeleft), .ready_left(ready_left),
    .high_score(high_score), .new_record(new_record)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  // kind: 0=score_clr 1=game_start 2=mole_en 3=game_end
  typedef struct {
    int kind;
    int cyc;
    int tl;
  } ev_t;
  ev_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input int t);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.tl   = t;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge CLK100MHZ);
  endtask

  always @(negedge CLK100MHZ) begin : monitor
    logic [3:0] s;
    ev_t e;
    s = {game_end, mole_en, game_start, score_clr};
    for (int k = 0; k < 4; k++) begin
      if (s[k] === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: strobe %0d at cycle %0d, expected none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.cyc != cyc || e.tl != int'(timeleft)) begin
            miscompares++;
            $display("FAIL sb_event: got strobe %0d cycle %0d timeleft %0d, expected strobe %0d cycle %0d timeleft %0d",
                     k, cyc, timeleft, e.kind, e.cyc, e.tl);
          end
        end
      end
    end
  end

  always @(posedge CLK100MHZ) begin
    if (cyc > 5000) begin
      $display("FAIL watchdog: cycle %0d, expected end before 5000", cyc);
      $fatal(1);
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_setup_en"}, setup_en, 1);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_timeleft"}, timeleft, 0);
    check({tag, "_ready_left"}, ready_left, 0);
    check({tag, "_high_score"}, high_score, 0);
    check({tag, "_new_record"}, new_record, 0);
  endtask

  task automatic run_round(input int gt, input int diff, input int sc, input bit disturb,
                           input int exp_hs, input int exp_nr);
    int t0, gs, ge, p;
    gametime   = 6'(gt);
    difficulty = 2'(diff);
    score      = 8'(sc);
    start      = 1'b1;
    t0 = cyc;
    gs = t0 + 31;
    ge = gs + 10 * gt;
    p  = (diff == 0) ? 20 : (diff == 1) ? 12 : 8;
    push(0, t0 + 1, 0);
    push(1, gs, gt);
    for (int m = p; m < 10 * gt; m += p) push(2, gs + m, gt - m / 10);
    push(3, ge, 0);
    step(1);
    start = 1'b0;
    check("ready_state", state, 1);
    check("ready_left_3", ready_left, 3);
    check("ready_setup_en", setup_en, 0);
    to_cyc(t0 + 11);
    check("ready_left_2", ready_left, 2);
    to_cyc(t0 + 21);
    check("ready_left_1", ready_left, 1);
    to_cyc(gs);
    check("play_state", state, 2);
    check("play_playing", playing, 1);
    check("play_timeleft", timeleft, gt);
    if (disturb) begin
      to_cyc(gs + 15);
      gametime   = 6'd63;
      difficulty = 2'd0;
      start      = 1'b1;
      step(1);
      start = 1'b0;
    end
    to_cyc(ge - 1);
    check("last_play_state", state, 2);
    check("last_play_timeleft", timeleft, 1);
    to_cyc(ge);
    check("over_state", state, 3);
    check("over_timeleft", timeleft, 0);
    check("over_playing", playing, 0);
    check("over_high_score", high_score, exp_hs);
    check("over_new_record", new_record, exp_nr);
    step(3);
    check("over_hold", state, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("idle_again_state", state, 0);
    check("idle_again_setup_en", setup_en, 1);
    check("idle_again_new_record", new_record, 0);
    check("idle_again_high_score", high_score, exp_hs);
  endtask

  initial begin
    int t0;
    step(3);
    RST_BTN = 1'b0;
    check_reset("reset");

    gametime = 6'd0;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("zero_gametime_state", state, 0);

    run_round(5, 0, 7, 1'b0, HS ? 7 : 0, HS ? 1 : 0);
    run_round(4, 2, 4, 1'b1, HS ? 7 : 0, 0);
    run_round(2, 1, 9, 1'b0, HS ? 9 : 0, HS ? 1 : 0);

    gametime   = 6'd5;
    difficulty = 2'd0;
    start      = 1'b1;
    t0 = cyc;
    push(0, t0 + 1, 0);
    step(1);
    start = 1'b0;
    to_cyc(t0 + 15);
    RST_BTN = 1'b1;
    step(1);
    RST_BTN = 1'b0;
    check_reset("rst_ready");

    gametime   = 6'd3;
    difficulty = 2'd2;
    start      = 1'b1;
    t0 = cyc;
    push(0, t0 + 1, 0);
    push(1, t0 + 31, 3);
    push(2, t0 + 39, 3);
    step(1);
    start = 1'b0;
    to_cyc(t0 + 43);
    RST_BTN = 1'b1;
    step(1);
    RST_BTN = 1'b0;
    check_reset("rst_play");

    run_round(1, 0, 0, 1'b0, 0, 0);

    step(5);
    check("sb_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
